// File: rtl/game_pkg.sv
// Shared game constants: screen size, pipe/bird geometry, LFSR seed and taps.
package game_pkg;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int PIPE_W   = 40;
  localparam int GAP_H    = 120;
  localparam int GAP_MIN  = 40;
  localparam int BIRD_X   = 300;
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // Taps 8,6,5,4 -> bits 7,5,4,3
  localparam logic [7:0] LFSR_TAPS = 8'hB8;
endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR, free running, shifts left with feedback into bit 0.
module lfsr8
  import game_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] o_val
);
  logic [7:0] r_val;

  always_ff @(posedge clk) begin
    if (rst) r_val <= LFSR_SEED;
    else     r_val <= {r_val[6:0], ^(r_val & LFSR_TAPS)};
  end

  assign o_val = r_val;
endmodule

// File: rtl/pipe_scroller.sv
// Two scrolling pipe obstacles: scroll divider, respawn with random gap,
// score counter and a registered pipe pixel flag for the mixer.
module pipe_scroller
  import game_pkg::*;
#(
  parameter int TICK_DIV     = 100000,
  parameter int SPEED        = 1,
  parameter int PIPE_W_P     = PIPE_W,
  parameter int GAP_H_P      = GAP_H,
  parameter int GAP_MIN_P    = GAP_MIN,
  parameter int SCREEN_W_P   = SCREEN_W,
  parameter int PIPE_SPACING = 320,
  parameter int BIRD_X_P     = BIRD_X
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_run,
  input  logic [9:0]  i_x,
  input  logic [9:0]  i_y,
  output logic        o_pipe,
  output logic        o_step,
  output logic [10:0] o_p0_r,
  output logic [8:0]  o_p0_gap,
  output logic [10:0] o_p1_r,
  output logic [8:0]  o_p1_gap,
  output logic [7:0]  o_score
);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);
  localparam logic [10:0] SP    = 11'(SPEED);
  localparam logic [10:0] PW    = 11'(PIPE_W_P);
  localparam logic [10:0] GH    = 11'(GAP_H_P);
  localparam logic [8:0]  GMIN  = 9'(GAP_MIN_P);
  localparam logic [10:0] SPC   = 11'(PIPE_SPACING);
  localparam logic [10:0] BX    = 11'(BIRD_X_P);
  localparam logic [10:0] P0_RST = 11'(SCREEN_W_P + PIPE_W_P);
  localparam logic [10:0] P1_RST = 11'(SCREEN_W_P + PIPE_W_P + PIPE_SPACING);
  localparam logic [8:0]  GAP_RST = 9'd180;

  logic [CW-1:0] r_cnt;
  logic          r_step;
  logic          r_pipe;
  logic [10:0]   r_p0_r, r_p1_r;
  logic [8:0]    r_p0_gap, r_p1_gap;
  logic [7:0]    r_score;
  logic [7:0]    w_lfsr;

  lfsr8 u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .o_val (w_lfsr)
  );

  function automatic logic hit(
    input logic [10:0] r,
    input logic [8:0]  gap,
    input logic [10:0] x,
    input logic [10:0] y
  );
    logic [10:0] left;
    logic [10:0] bot;
    left = (r >= PW) ? r - PW : 11'd0;
    bot  = {2'b00, gap} + GH;
    return (x >= left) && (x < r) && ((y < {2'b00, gap}) || (y >= bot));
  endfunction

  logic        w_step;
  logic        w_rsp0, w_rsp1;
  logic [10:0] w_dec0, w_dec1;
  logic [10:0] w_p0_nx, w_p1_nx;
  logic        w_x0, w_x1;
  logic [8:0]  w_sum;
  logic [7:0]  w_score_nx;
  logic        w_hit;

  always_comb begin
    w_step = i_run && (r_cnt == CNT_MAX);
    w_rsp0 = r_p0_r <= SP;
    w_rsp1 = r_p1_r <= SP;
    w_dec0 = r_p0_r - SP;
    w_dec1 = r_p1_r - SP;
    // Only one pipe can respawn per step, so the other's decrement is its new r
    w_p0_nx = w_rsp0 ? w_dec1 + SPC : w_dec0;
    w_p1_nx = w_rsp1 ? w_dec0 + SPC : w_dec1;
    w_x0 = (r_p0_r > BX) && (w_p0_nx <= BX);
    w_x1 = (r_p1_r > BX) && (w_p1_nx <= BX);
    w_sum = {1'b0, r_score} + {8'd0, w_x0} + {8'd0, w_x1};
    w_score_nx = w_sum[8] ? 8'hFF : w_sum[7:0];
    w_hit = hit(r_p0_r, r_p0_gap, {1'b0, i_x}, {1'b0, i_y})
         || hit(r_p1_r, r_p1_gap, {1'b0, i_x}, {1'b0, i_y});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_step   <= 1'b0;
      r_pipe   <= 1'b0;
      r_p0_r   <= P0_RST;
      r_p1_r   <= P1_RST;
      r_p0_gap <= GAP_RST;
      r_p1_gap <= GAP_RST;
      r_score  <= 8'd0;
    end else begin
      r_pipe <= w_hit;
      r_step <= w_step;
      if (!i_run)      r_cnt <= '0;
      else if (w_step) r_cnt <= '0;
      else             r_cnt <= r_cnt + 1'b1;
      if (w_step) begin
        r_p0_r  <= w_p0_nx;
        r_p1_r  <= w_p1_nx;
        r_score <= w_score_nx;
        if (w_rsp0) r_p0_gap <= GMIN + {1'b0, w_lfsr};
        if (w_rsp1) r_p1_gap <= GMIN + {1'b0, w_lfsr};
      end
    end
  end

  assign o_pipe   = r_pipe;
  assign o_step   = r_step;
  assign o_p0_r   = r_p0_r;
  assign o_p1_r   = r_p1_r;
  assign o_p0_gap = r_p0_gap;
  assign o_p1_gap = r_p1_gap;
  assign o_score  = r_score;
endmodule

// File: tb/tb_pipe_scroller.sv
// Directed bench for pipe_scroller with TICK_DIV=4.
module tb_pipe_scroller;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_run = 1'b0;
  logic [9:0]  i_x = '0;
  logic [9:0]  i_y = '0;
  logic        o_pipe, o_step;
  logic [10:0] o_p0_r, o_p1_r;
  logic [8:0]  o_p0_gap, o_p1_gap;
  logic [7:0]  o_score;

  int vec = 0;
  int err = 0;

  logic [7:0] m_lfsr = 8'hA5;
  logic [7:0] m_prev = 8'hA5;

  always #10 clk = ~clk;

  always @(posedge clk) begin
    m_prev <= m_lfsr;
    if (rst) m_lfsr <= 8'hA5;
    else m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  pipe_scroller #(.TICK_DIV(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .i_run    (i_run),
    .i_x      (i_x),
    .i_y      (i_y),
    .o_pipe   (o_pipe),
    .o_step   (o_step),
    .o_p0_r   (o_p0_r),
    .o_p0_gap (o_p0_gap),
    .o_p1_r   (o_p1_r),
    .o_p1_gap (o_p1_gap),
    .o_score  (o_score)
  );

  task automatic chk_reset_vals(input string tag);
    vec++;
    if ({o_p0_r, o_p1_r, o_p0_gap, o_p1_gap, o_score, o_step, o_pipe} !==
        {11'd680, 11'd1000, 9'd180, 9'd180, 8'd0, 1'b0, 1'b0}) begin
      err++;
      $display("FAIL %s: got p0=%0d p1=%0d g0=%0d g1=%0d sc=%0d st=%b px=%b, want 680 1000 180 180 0 0 0",
               tag, o_p0_r, o_p1_r, o_p0_gap, o_p1_gap, o_score, o_step, o_pipe);
    end
  endtask

  task automatic run_until_p0(input logic [10:0] tgt, input int budget);
    bit ok;
    ok = 0;
    i_run = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (o_p0_r == tgt) begin ok = 1; break; end
    end
    i_run = 1'b0;
    vec++;
    if (!ok) begin
      err++;
      $display("FAIL reach_p0: got p0=%0d, want %0d within %0d cycles", o_p0_r, tgt, budget);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_reset_vals("reset");
  endtask

  task automatic test_stepping;
    int n, last, gap_bad;
    n = 0; last = -1; gap_bad = 0;
    i_run = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (i == 16) i_run = 1'b0;
      if (o_step) begin
        if (last >= 0 && i - last != 4) gap_bad++;
        if (last < 0 && i != 4) gap_bad++;
        last = i;
        n++;
      end
    end
    vec++;
    if (n != 4) begin err++; $display("FAIL step_count: got %0d, want 4", n); end
    vec++;
    if (gap_bad != 0) begin err++; $display("FAIL step_spacing: got %0d bad intervals, want 0", gap_bad); end
    vec++;
    if (o_p0_r !== 11'd676 || o_p1_r !== 11'd996) begin
      err++; $display("FAIL step_geom: got p0=%0d p1=%0d, want 676 996", o_p0_r, o_p1_r);
    end
  endtask

  task automatic test_freeze;
    int n, lat;
    n = 0; lat = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (o_step) n++;
    end
    vec++;
    if (n != 0 || o_p0_r !== 11'd676 || o_p1_r !== 11'd996) begin
      err++; $display("FAIL freeze: got steps=%0d p0=%0d p1=%0d, want 0 676 996", n, o_p0_r, o_p1_r);
    end
    i_run = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (o_step) begin lat = i; break; end
    end
    i_run = 1'b0;
    vec++;
    if (lat != 4 || o_p0_r !== 11'd675) begin
      err++; $display("FAIL resume: got latency=%0d p0=%0d, want 4 675", lat, o_p0_r);
    end
  endtask

  task automatic test_pixel;
    logic [9:0] xs [4];
    logic [9:0] ys [4];
    logic       ex [4];
    xs = '{10'd370, 10'd370, 10'd370, 10'd400};
    ys = '{10'd100, 10'd200, 10'd300, 10'd100};
    ex = '{1'b1, 1'b0, 1'b1, 1'b0};
    run_until_p0(11'd400, 2000);
    for (int i = 0; i < 4; i++) begin
      i_x = xs[i];
      i_y = ys[i];
      @(negedge clk);
      vec++;
      if (o_pipe !== ex[i]) begin
        err++; $display("FAIL pixel(%0d,%0d): got %b, want %b", xs[i], ys[i], o_pipe, ex[i]);
      end
    end
    i_x = 10'd0;
    i_y = 10'd0;
  endtask

  task automatic test_score;
    vec++;
    if (o_score !== 8'd0) begin err++; $display("FAIL score_pre: got %0d, want 0", o_score); end
    run_until_p0(11'd300, 600);
    vec++;
    if (o_score !== 8'd1) begin err++; $display("FAIL score_cross: got %0d, want 1", o_score); end
    force dut.r_score = 8'd255;
    @(negedge clk);
    release dut.r_score;
    @(negedge clk);
    vec++;
    if (o_score !== 8'd255) begin err++; $display("FAIL score_forced: got %0d, want 255", o_score); end
  endtask

  task automatic test_respawn;
    bit ok;
    logic [8:0] g;
    run_until_p0(11'd1, 2000);
    ok = 0;
    i_run = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (o_step) begin ok = 1; break; end
    end
    i_run = 1'b0;
    g = 9'd40 + {1'b0, m_prev};
    vec++;
    if (!ok || o_p0_r !== 11'd640 || o_p1_r !== 11'd320) begin
      err++; $display("FAIL respawn_r: got p0=%0d p1=%0d, want 640 320", o_p0_r, o_p1_r);
    end
    vec++;
    if (o_p0_gap !== g || o_p0_gap < 9'd40 || o_p0_gap > 9'd295) begin
      err++; $display("FAIL respawn_gap: got %0d, want %0d", o_p0_gap, g);
    end
  endtask

  task automatic test_saturate;
    bit ok;
    ok = 0;
    i_run = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (o_p1_r == 11'd300) begin ok = 1; break; end
    end
    i_run = 1'b0;
    vec++;
    if (!ok || o_score !== 8'd255) begin
      err++; $display("FAIL score_sat: got p1=%0d score=%0d, want 300 255", o_p1_r, o_score);
    end
  endtask

  task automatic test_reset_midrun;
    i_run = 1'b1;
    i_x = 10'd370;
    i_y = 10'd100;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_vals("reset_midrun");
    rst = 1'b0;
    i_run = 1'b0;
  endtask

  initial begin
    test_reset;
    test_stepping;
    test_freeze;
    test_pixel;
    test_score;
    test_respawn;
    test_saturate;
    test_reset_midrun;
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule

// File: doc/pipe_scroller.md
Name: pipe_scroller

Overview:
- Generates the two scrolling pipe obstacles for the game.
- Feeds the top-level pixel mixer with a registered pipe pixel flag for the current VGA (x, y).
- Exports pipe geometry and a score counter to the collision/game-state logic.
- Runs in the 50 MHz `clk` domain with an internal scroll-tick divider, so the top level needs no derived clocks.

Parameters:
- TICK_DIV, 100000: `clk` cycles per scroll step.
- SPEED, 1: pixels moved left per step.
- PIPE_W, 40: pipe width in pixels.
- GAP_H, 120: vertical gap height in pixels.
- GAP_MIN, 40: minimum gap top row.
- SCREEN_W, 640: visible width.
- PIPE_SPACING, 320: horizontal distance between the two pipes' right edges.
- BIRD_X, 300: bird left column; a pipe passing it scores.

Ports:
- clk  in  1  board clock, 50 MHz
- rst  in  1  synchronous active-high reset
- i_run  in  1  scrolling enabled; low means frozen, e.g. game over
- i_x  in  10  current pixel column from vga_timing
- i_y  in  10  current pixel row from vga_timing
- o_pipe  out  1  registered pipe pixel flag for the pixel mixer
- o_step  out  1  one-cycle pulse on each scroll step
- o_p0_r  out  11  pipe 0 right edge (exclusive)
- o_p0_gap  out  9  pipe 0 gap top row
- o_p1_r  out  11  pipe 1 right edge (exclusive)
- o_p1_gap  out  9  pipe 1 gap top row
- o_score  out  8  pipes passed, saturating

Behaviour:
- One clock domain (`clk`). Reset is synchronous and active-high (`rst`), sampled on the rising edge of `clk`. It takes priority over all other logic, including mid-scroll.
- Reset values:
  - o_pipe=0, o_step=0, tick counter=0
  - o_p0_r=SCREEN_W+PIPE_W (680)
  - o_p1_r=680+PIPE_SPACING (1000)
  - o_p0_gap=o_p1_gap=180
  - o_score=0, LFSR=8'hA5
- Tick counter:
  - While i_run=1 it counts 0..TICK_DIV-1.
  - On the cycle it equals TICK_DIV-1 it wraps to 0 and o_step=1 on the next cycle; o_step is otherwise 0.
  - While i_run=0 the counter is cleared and no step occurs. Geometry and score hold.
- LFSR:
  - 8-bit Fibonacci, taps 8,6,5,4, shifting left with feedback into bit 0.
  - Advances every `clk` cycle regardless of i_run, so gap choice depends on player timing.
  - Reset seed is non-zero, so the LFSR never locks up.
- Scroll, on each step cycle (same cycle the counter wraps):
  - Each pipe with r > SPEED: r <= r - SPEED.
  - A pipe with r <= SPEED respawns: r <= (other pipe's r after this step's update) + PIPE_SPACING, gap <= GAP_MIN + LFSR[7:0] (range 40..295; gap bottom <= 415 < 480).
  - The two pipes never respawn in the same step, since spacing exceeds SPEED.
  - All arithmetic is 11-bit unsigned; no value exceeds 2047.
- Score:
  - On a step where a pipe's r goes from > BIRD_X to <= BIRD_X, add 1.
  - If both pipes cross in the same step, add 2.
  - Saturates at 255, never wraps.
- Pixel path, registered with 1-cycle latency after i_x/i_y:
  - o_pipe=1 if, for either pipe, zero-extended i_x >= max(r-PIPE_W, 0), i_x < r, and (i_y < gap or i_y >= gap+GAP_H).
  - Pipes with r-PIPE_W >= SCREEN_W are simply off-screen and draw nothing.
  - The pixel path uses geometry registered before the update, so a step changes the display from the next cycle.
- i_run toggling mid-count restarts the divider from 0; no partial step is carried over.

Decomposition:
- Shared package `game_pkg`:
  - Screen constants SCREEN_W=640, SCREEN_H=480.
  - Default PIPE_W, GAP_H, GAP_MIN, BIRD_X, which the bird and collision logic also use.
  - LFSR seed/taps constants.
- Sub-module `lfsr8` (clk, rst, o_val[7:0]), reusable elsewhere for random effects.
- Tick divider stays inline.

Test Plan (TICK_DIV=4 for speed):
- Reset: assert rst 2 cycles -> o_p0_r=680, o_p1_r=1000, gaps 180, o_score=0, o_step=0, o_pipe=0.
- Stepping: i_run=1 for 16 cycles -> exactly 4 o_step pulses, 4 cycles apart; o_p0_r=676, o_p1_r=996.
- Freeze: drop i_run for 20 cycles -> no o_step, geometry unchanged. Re-raise -> first step 4 cycles later.
- Score: run until o_p0_r reaches 300 -> o_score=1 on that step. Force score to 255 and cross again -> remains 255.
- Respawn: run until o_p0_r=1 -> next step o_p0_r = o_p1_r(new)+320; o_p0_gap within 40..295 and equal to GAP_MIN plus the sampled LFSR.
- Pixel: o_p0_r=400, gap=180; drive (x=370,y=100) -> o_pipe=1 next cycle; (370,200) -> 0; (370,300) -> 1; (400,100) -> 0. Apply rst mid-run -> all outputs return to reset values next cycle.
